// File: rtl/timer_irq.sv
// timer_irq: machine timer and interrupt-source unit.
//
// Holds the 64-bit mtime counter, the 64-bit mtimecmp compare register and
// the msip software-interrupt bit behind a valid/ready register port, and
// synchronises the asynchronous external interrupt line into clk.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   req_valid/req_ready   register request handshake
//   req_write             1 = write, 0 = read
//   req_addr[4:0]         byte offset (bits [1:0] ignored)
//   req_wdata[31:0]       full-word write data
//   resp_valid/resp_ready response handshake (one response outstanding max)
//   resp_rdata[31:0]      read data (0 for writes and errors)
//   resp_error            unmapped offset
//   ext_irq               asynchronous level external interrupt
//   meip, mtip, msip      interrupt-pending levels to the CSR unit
//
// Register map: 0x00 msip, 0x04/0x08 mtimecmp lo/hi, 0x0C/0x10 mtime lo/hi,
// 0x14..0x1C unmapped (error response, no side effect).
module timer_irq #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  input  logic        ext_irq,
  output logic        meip,
  output logic        mtip,
  output logic        msip
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  logic [15:0] presc_cnt;
  logic        tick;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        ext_sync_p0;

  logic        accept;
  logic        wr_en;
  logic [2:0]  idx;
  logic        unmapped;
  logic [31:0] rd_data;
  logic        unused_addr;

  assign req_ready   = !resp_valid || resp_ready;
  assign accept      = req_valid && req_ready;
  assign wr_en       = accept && req_write;
  assign idx         = req_addr[4:2];
  assign unmapped    = (idx > 3'd4);
  assign tick        = (presc_cnt == PRESCALE_LAST);
  assign unused_addr = &{1'b0, req_addr[1:0]};

  // Read mux works on pre-edge register contents.
  always_comb begin
    rd_data = 32'd0;
    case (idx)
      3'd0:    rd_data = {31'd0, msip};
      3'd1:    rd_data = mtimecmp[31:0];
      3'd2:    rd_data = mtimecmp[63:32];
      3'd3:    rd_data = mtime[31:0];
      3'd4:    rd_data = mtime[63:32];
      default: rd_data = 32'd0;
    endcase
  end

  // Prescaler keeps running even when software writes mtime.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= 16'd0;
    end else if (tick) begin
      presc_cnt <= 16'd0;
    end else begin
      presc_cnt <= presc_cnt + 16'd1;
    end
  end

  // A write to either mtime half suppresses the whole 64-bit increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime <= 64'd0;
    end else if (wr_en && idx == 3'd3) begin
      mtime[31:0] <= req_wdata;
    end else if (wr_en && idx == 3'd4) begin
      mtime[63:32] <= req_wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
    end else if (wr_en) begin
      case (idx)
        3'd0:    msip            <= req_wdata[0];
        3'd1:    mtimecmp[31:0]  <= req_wdata;
        3'd2:    mtimecmp[63:32] <= req_wdata;
        default: ;
      endcase
    end
  end

  // Registered compare on pre-edge values; external line through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtip        <= 1'b0;
      ext_sync_p0 <= 1'b0;
      meip        <= 1'b0;
    end else begin
      mtip        <= (mtime >= mtimecmp);
      ext_sync_p0 <= ext_irq;
      meip        <= ext_sync_p0;
    end
  end

  // Response register: loads on accept, holds until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_rdata <= (req_write || unmapped) ? 32'd0 : rd_data;
      resp_error <= unmapped;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_irq.sv
// Bench for timer_irq (PRESCALE=4): behavioural model compared every cycle,
// plus directed transactions with hand-computed expectations.
module tb_timer_irq;

  localparam int unsigned P = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [4:0]  req_addr = 5'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        ext_irq = 1'b0;
  logic        meip, mtip, msip;

  int n_tests = 0;
  int n_fail  = 0;

  timer_irq #(.PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .ext_irq(ext_irq), .meip(meip), .mtip(mtip), .msip(msip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint unsigned m_cyc = 0;     // edges since reset release
  logic [63:0] m_time = 64'd0;
  logic [63:0] m_cmp  = '1;
  logic        m_msip = 1'b0, m_mtip = 1'b0;
  logic        m_s1 = 1'b0, m_meip = 1'b0;
  logic        m_rv = 1'b0, m_err = 1'b0;
  logic [31:0] m_rdata = 32'd0;

  logic        m_acc, m_tick, m_wr;
  logic [31:0] m_rd;
  int          m_off;

  always_comb begin
    m_acc  = req_valid && (!m_rv || resp_ready);
    m_wr   = m_acc && req_write;
    m_tick = ((m_cyc % P) == P - 1);
    m_off  = int'(req_addr) & 32'h1C;
    m_rd   = 32'd0;
    if      (m_off == 'h00) m_rd = {31'd0, m_msip};
    else if (m_off == 'h04) m_rd = m_cmp[31:0];
    else if (m_off == 'h08) m_rd = m_cmp[63:32];
    else if (m_off == 'h0C) m_rd = m_time[31:0];
    else if (m_off == 'h10) m_rd = m_time[63:32];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0; m_time <= 64'd0; m_cmp <= '1; m_msip <= 1'b0; m_mtip <= 1'b0;
      m_s1 <= 1'b0; m_meip <= 1'b0; m_rv <= 1'b0; m_err <= 1'b0; m_rdata <= 32'd0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_wr && m_off == 'h0C)      m_time <= {m_time[63:32], req_wdata};
      else if (m_wr && m_off == 'h10) m_time <= {req_wdata, m_time[31:0]};
      else if (m_tick)                m_time <= m_time + 64'd1;
      if (m_wr && m_off == 'h04) m_cmp <= {m_cmp[63:32], req_wdata};
      if (m_wr && m_off == 'h08) m_cmp <= {req_wdata, m_cmp[31:0]};
      if (m_wr && m_off == 'h00) m_msip <= req_wdata[0];
      m_mtip <= (m_time >= m_cmp);
      m_s1   <= ext_irq;
      m_meip <= m_s1;
      if (m_acc) begin
        m_rv    <= 1'b1;
        m_err   <= (m_off > 'h10);
        m_rdata <= req_write ? 32'd0 : m_rd;
      end else if (resp_ready) begin
        m_rv <= 1'b0;
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_req_ready", req_ready, !m_rv || resp_ready);
      chk("model_resp_valid", resp_valid, m_rv);
      if (m_rv) begin
        chk("model_resp_rdata", resp_rdata, m_rdata);
        chk("model_resp_error", resp_error, m_err);
      end
      chk("model_mtip", mtip, m_mtip);
      chk("model_msip", msip, m_msip);
      chk("model_meip", meip, m_meip);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic xfer(input bit wr, input logic [4:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("xfer_accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    chk("resp_one_cycle_latency", resp_valid, 1'b1);
    rd = resp_rdata;
    er = resp_error;
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, r1, r2;
    logic        er;
    int          k;

    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_resp_valid", resp_valid, 1'b0);
    chk("reset_irqs", {meip, mtip, msip}, 3'b000);

    xfer(1'b0, 5'h0C, 32'd0, rd, er); chk("reset_mtime_lo", rd, 32'd0);
    xfer(1'b0, 5'h10, 32'd0, rd, er); chk("reset_mtime_hi", rd, 32'd0);
    xfer(1'b0, 5'h00, 32'd0, rd, er); chk("reset_msip_reg", rd, 32'd0);
    xfer(1'b0, 5'h04, 32'd0, rd, er); chk("reset_cmp_lo", rd, 32'hFFFF_FFFF);
    xfer(1'b0, 5'h08, 32'd0, rd, er); chk("reset_cmp_hi", rd, 32'hFFFF_FFFF);
    chk("reset_read_no_error", er, 1'b0);

    // mtip rise/fall around mtimecmp = 10
    xfer(1'b1, 5'h08, 32'd0, rd, er);
    xfer(1'b1, 5'h0C, 32'd0, rd, er);
    xfer(1'b1, 5'h04, 32'd10, rd, er);
    chk("write_rdata_zero", rd, 32'd0);
    k = 0;
    while (!mtip && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("mtip_rise_timeout", (k < 100), 1'b1);
    xfer(1'b0, 5'h0C, 32'd0, rd, er); chk("mtime_at_mtip_rise", rd, 32'd10);
    xfer(1'b1, 5'h04, 32'd100, rd, er);
    chk("mtip_held_at_cmp_write", mtip, 1'b1);
    @(negedge clk);
    chk("mtip_fall_after_cmp_raise", mtip, 1'b0);

    // increment rate: 40 edges between accepts -> exactly 10 ticks
    xfer(1'b0, 5'h0C, 32'd0, r1, er);
    repeat (38) @(negedge clk);
    xfer(1'b0, 5'h0C, 32'd0, r2, er);
    chk("mtime_rate_40_cycles", r2 - r1, 32'd10);

    // 64-bit wrap with mtimecmp = 0
    xfer(1'b1, 5'h04, 32'd0, rd, er);
    xfer(1'b1, 5'h10, 32'hFFFF_FFFF, rd, er);
    xfer(1'b1, 5'h0C, 32'hFFFF_FFFE, rd, er);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("mtip_across_wrap", mtip, 1'b1);
    end
    xfer(1'b0, 5'h10, 32'd0, rd, er); chk("mtime_hi_after_wrap", rd, 32'd0);

    // msip and unmapped offsets
    xfer(1'b1, 5'h00, 32'hFFFF_FFFF, rd, er);
    chk("msip_set", msip, 1'b1);
    xfer(1'b0, 5'h00, 32'd0, rd, er); chk("msip_readback", rd, 32'd1);
    xfer(1'b1, 5'h00, 32'd0, rd, er);
    chk("msip_clear", msip, 1'b0);
    xfer(1'b1, 5'h18, 32'h1234_5678, rd, er);
    chk("unmapped_wr_error", er, 1'b1);
    chk("unmapped_wr_rdata", rd, 32'd0);
    xfer(1'b0, 5'h18, 32'd0, rd, er);
    chk("unmapped_rd_error", er, 1'b1);
    chk("unmapped_rd_rdata", rd, 32'd0);
    xfer(1'b0, 5'h04, 32'd0, rd, er); chk("unmapped_no_side_effect", rd, 32'd0);

    // back-pressure
    xfer(1'b1, 5'h08, 32'h0000_00AB, rd, er);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h08;
    @(negedge clk);
    chk("bp_resp_valid", resp_valid, 1'b1);
    chk("bp_rdata", resp_rdata, 32'hAB);
    req_write = 1'b1; req_addr = 5'h00; req_wdata = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", resp_valid, 1'b1);
      chk("bp_hold_rdata", resp_rdata, 32'hAB);
      chk("bp_req_ready_low", req_ready, 1'b0);
      chk("bp_write_stalled", msip, 1'b0);
    end
    resp_ready = 1'b1;
    #1 chk("bp_release_ready", req_ready, 1'b1);
    @(negedge clk);
    chk("bp_next_accepted", resp_valid, 1'b1);
    chk("bp_next_rdata", resp_rdata, 32'd0);
    chk("bp_next_msip", msip, 1'b1);
    req_valid = 1'b0; req_write = 1'b0;

    // external interrupt synchroniser
    @(negedge clk);
    #3 ext_irq = 1'b1;
    k = 0;
    while (!meip && k < 6) begin
      @(negedge clk);
      k++;
    end
    chk("meip_rise_within_3", (k <= 3), 1'b1);
    #7 ext_irq = 1'b0;
    k = 0;
    while (meip && k < 6) begin
      @(negedge clk);
      k++;
    end
    chk("meip_fall_within_3", (k <= 3), 1'b1);
    ext_irq = 1'b1;

    // reset with a pending response
    xfer(1'b1, 5'h08, 32'd0, rd, er);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h08;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_reset_resp_valid", resp_valid, 1'b1);
    chk("pre_reset_irqs", {meip, mtip, msip}, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_resp_valid", resp_valid, 1'b0);
    chk("async_reset_rdata", resp_rdata, 32'd0);
    chk("async_reset_error", resp_error, 1'b0);
    chk("async_reset_irqs", {meip, mtip, msip}, 3'b000);
    chk("async_reset_req_ready", req_ready, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_resp_after_reset", resp_valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/timer_irq.md
# timer_irq

Machine timer and interrupt-source unit that generates the three machine interrupt-pending levels (meip, mtip, msip) consumed by the CSR unit. It holds the 64-bit mtime counter, the 64-bit mtimecmp compare register and the msip software-interrupt bit, all memory-mapped on a simple valid/ready register port driven by the load/store path. It also synchronises the asynchronous external interrupt line into the core clock domain.

## Interface
Parameters:
- PRESCALE, 1, core cycles per mtime increment; legal range 1..65535.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  register access request.
- req_ready  output  1  request accepted this cycle when high with req_valid.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  5  byte offset, word aligned; bits [1:0] ignored.
- req_wdata  input  32  write data; full-word writes only.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer takes the response.
- resp_rdata  output  32  read data; 0 for writes and errors.
- resp_error  output  1  unmapped offset.
- ext_irq  input  1  asynchronous level external interrupt.
- meip  output  1  to CSR: external interrupt pending.
- mtip  output  1  to CSR: timer interrupt pending.
- msip  output  1  to CSR: software interrupt pending.

## Operation
- Register map (offset: register):
  - 0x00: msip; bit 0 read/write, bits [31:1] read 0, writes ignored.
  - 0x04: mtimecmp[31:0].
  - 0x08: mtimecmp[63:32].
  - 0x0C: mtime[31:0].
  - 0x10: mtime[63:32].
  - 0x14..0x1C: unmapped. Reads return 0 and writes have no effect, with resp_error=1.
- Prescaler: a 16-bit counter runs 0..PRESCALE-1. When the count is PRESCALE-1 a tick fires and the counter returns to 0. With PRESCALE=1 a tick fires every cycle.
- On a tick, mtime increments by 1. It wraps from 2^64-1 to 0 with no flag.
- A write to either mtime half replaces that half. That cycle's increment is suppressed for the full 64 bits. The prescaler keeps running.
- A write to one mtimecmp half leaves the other half unchanged. Software is responsible for the ordering of the two halves.
- mtip is a registered compare: mtip <= (mtime >= mtimecmp), evaluated on register values before the edge. It stays high until mtimecmp is raised above mtime or mtime wraps.
- msip output equals the msip register bit.
- meip is ext_irq passed through a two-flop synchroniser. It is a level with no latching and no edge detection.
- Handshake:
  - req_ready = !resp_valid || resp_ready, so at most one response is outstanding.
  - A request is accepted when req_valid && req_ready.
  - The response registers load on the accepting edge.
  - resp_valid holds, and resp_rdata/resp_error stay stable, until resp_valid && resp_ready.
  - Back-to-back accepts are allowed when resp_ready is held high.
- Read data reflects register contents before the accepting edge, i.e. before that edge's increment.

## Timing
- Reset values:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0.
  - Synchroniser flops=0.
  - resp_valid=0, resp_rdata=0, resp_error=0.
  - meip=0, mtip=0, msip=0, req_ready=1.
- Reset asserted mid-transaction drops any pending response immediately. No response is produced after reset release.
- Read latency is 1 cycle: accept at edge N, resp_valid high after edge N.
- A write becomes visible at edge N. A read accepted at edge N+1 returns the new value.
- mtip timing:
  - mtimecmp write at edge N: mtip reflects the new compare after edge N+1.
  - The tick that makes mtime equal mtimecmp at edge N: mtip rises after edge N+1.
- meip latency: 2 to 3 cycles after an ext_irq transition, depending on the phase of the asynchronous input.
- Simultaneous tick and mtime write: the write wins and there is no increment.
- Wrap with mtimecmp=0: mtip stays 1 across the wrap.

## Test plan
- Reset, then read offsets 0x00..0x10 -> reads return 0, 0xFFFFFFFF, 0xFFFFFFFF, 0, 0; mtip=0, msip=0, meip=0; each resp_valid arrives exactly 1 cycle after accept.
- PRESCALE=4: write mtime lo=0, then count → mtime increments once every 4 cycles; write mtimecmp hi=0, lo=10 → mtip rises 1 cycle after mtime reaches 10; write mtimecmp lo=100 → mtip falls 1 cycle later.
- Write mtime hi=0xFFFFFFFF, lo=0xFFFFFFFE with PRESCALE=1 → mtime wraps to 0 two ticks later; with mtimecmp=0, mtip stays 1 throughout.
- Write 0xFFFFFFFF to 0x00 → msip=1 and readback=1; write 0 → msip=0. Access 0x18 → resp_error=1 and rdata=0, with no state change.
- Hold resp_ready=0 after a read → resp_valid held, rdata stable, req_ready=0 and new requests stalled; release → completes, then the next request is accepted on the same edge.
- Toggle ext_irq asynchronously → meip follows within 3 cycles; assert rst_n low with resp_valid=1 → all outputs return to reset values immediately.
